// File: rtl/gbt_counter_checker.sv
// Receive-side checker for the GBT counter test pattern: locks onto an
// incrementing word stream, flags breaks in it and counts words/errors while locked.
module gbt_counter_checker #(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic              rx_ready_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_ib,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              error_o,
    output logic [1:0]        state_ob,
    output logic [CNT_W-1:0]  word_cnt_ob,
    output logic [CNT_W-1:0]  err_cnt_ob
);
    typedef enum logic [1:0] {IDLE = 2'b00, SEEK = 2'b01, LOCKED = 2'b10} state_t;

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int ER_W = $clog2(UNLOCK_ERR + 1);

    state_t            state;
    logic [DATA_W-1:0] prev;
    logic [MR_W-1:0]   match_run;
    logic [ER_W-1:0]   err_run;
    logic              match;
    logic              word_inc;
    logic              err_inc;

    assign match    = (data_ib == prev + DATA_W'(1));
    assign word_inc = rx_ready_i && data_valid_i && (state == LOCKED);
    assign err_inc  = word_inc && !match;
    assign state_ob = state;

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            state       <= IDLE;
            prev        <= '0;
            match_run   <= '0;
            err_run     <= '0;
            locked_o    <= 1'b0;
            error_o     <= 1'b0;
            word_cnt_ob <= '0;
            err_cnt_ob  <= '0;
        end else begin
            error_o <= err_inc;

            // clear wins over a same-cycle increment; counters stick at all-ones
            if (clear_i)
                word_cnt_ob <= '0;
            else if (word_inc && word_cnt_ob != '1)
                word_cnt_ob <= word_cnt_ob + CNT_W'(1);
            if (clear_i)
                err_cnt_ob <= '0;
            else if (err_inc && err_cnt_ob != '1)
                err_cnt_ob <= err_cnt_ob + CNT_W'(1);

            if (!rx_ready_i) begin
                state     <= IDLE;
                locked_o  <= 1'b0;
                match_run <= '0;
                err_run   <= '0;
            end else if (data_valid_i) begin
                prev <= data_ib;
                case (state)
                    IDLE: begin
                        match_run <= '0;
                        state     <= SEEK;
                    end
                    SEEK: begin
                        if (!match)
                            match_run <= '0;
                        else if (match_run == MR_W'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            locked_o  <= 1'b1;
                            match_run <= '0;
                            err_run   <= '0;
                        end else
                            match_run <= match_run + MR_W'(1);
                    end
                    LOCKED: begin
                        if (match)
                            err_run <= '0;
                        else if (err_run == ER_W'(UNLOCK_ERR - 1)) begin
                            state     <= SEEK;
                            locked_o  <= 1'b0;
                            match_run <= '0;
                            err_run   <= '0;
                        end else
                            err_run <= err_run + ER_W'(1);
                    end
                    default: begin
                        state    <= IDLE;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
